boot_controller: RTL

BOOT_CONTROLLER -- requirements
Module: boot_controller

---
 rtl/boot_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/boot_controller.sv
// boot_controller
//   Loads a program image from a UART byte stream into a nibble-wide memory
//   while holding the CPU in halt, then pulses a CPU restart. In RUN the CPU
//   owns the memory write port; in every other state the loader owns it.
//
// Ports
//   clk_i          system clock, rising-edge
//   reset_i        asynchronous active-low reset
//   p_programm_i   level request for programming mode
//   rx_data_i      received byte
//   rx_valid_i     one-cycle strobe qualifying rx_data_i
//   cpu_we_i       CPU write enable
//   cpu_addr_i     CPU write address
//   cpu_data_i     CPU write data
//   mem_we_o       arbitrated memory write enable
//   mem_addr_o     arbitrated memory write address
//   mem_data_o     arbitrated memory write data
//   cpu_halt_o     CPU must not advance while high
//   cpu_restart_o  one-cycle pulse: CPU program counter back to 0
//   busy_o         high in every state except RUN
//   err_o          sticky: a byte was dropped or the memory overflowed
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | CPU owns the memory port; loader idle
// HALT    | CPU halted, waiting for a byte or for the request to drop
// WR_HI   | writing upper nibble of latched byte at ptr
// WR_LO   | writing lower nibble of latched byte at ptr
// FULL    | every address loaded; further bytes are rejected
// RESTART | one-cycle CPU restart pulse, then back to RUN

module boot_controller #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            p_programm_i,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_valid_i,
  input  logic                            cpu_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       cpu_data_i,
  output logic                            mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [REGISTER_WIDTH-1:0]       mem_data_o,
  output logic                            cpu_halt_o,
  output logic                            cpu_restart_o,
  output logic                            busy_o,
  output logic                            err_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT,
    S_WR_HI,
    S_WR_LO,
    S_FULL,
    S_RESTART
  } state_e;

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] PTR_LAST =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

  state_e                            state_q, state_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0]   ptr_q, ptr_d;
  logic [7:0]                        latch_q, latch_d;
  logic                              err_q, err_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      latch_q <= latch_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    latch_d       = latch_q;
    err_d         = err_q;
    mem_we_o      = 1'b0;
    mem_addr_o    = ptr_q;
    mem_data_o    = '0;
    cpu_halt_o    = 1'b1;
    cpu_restart_o = 1'b0;
    busy_o        = 1'b1;

    unique case (state_q)
      S_RUN: begin
        cpu_halt_o = 1'b0;
        busy_o     = 1'b0;
        mem_we_o   = cpu_we_i;
        mem_addr_o = cpu_addr_i;
        mem_data_o = cpu_data_i;
        if (p_programm_i) begin
          state_d = S_HALT;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
      end

      // A byte arriving together with the request dropping is still taken;
      // the restart happens on the HALT visit after the byte is written.
      S_HALT: begin
        if (rx_valid_i) begin
          latch_d = rx_data_i;
          state_d = S_WR_HI;
        end else if (!p_programm_i) begin
          state_d = S_RESTART;
        end
      end

      S_WR_HI: begin
        mem_we_o   = 1'b1;
        mem_data_o = REGISTER_WIDTH'(latch_q[7:4]);
        ptr_d      = ptr_q + MEMORY_ADDRESS_WIDTH'(1);
        state_d    = S_WR_LO;
        if (rx_valid_i) err_d = 1'b1;
      end

      S_WR_LO: begin
        mem_we_o   = 1'b1;
        mem_data_o = REGISTER_WIDTH'(latch_q[3:0]);
        ptr_d      = ptr_q + MEMORY_ADDRESS_WIDTH'(1);
        state_d    = (ptr_q == PTR_LAST) ? S_FULL : S_HALT;
        if (rx_valid_i) err_d = 1'b1;
      end

      // No wrap-around: the pointer has rolled to 0 but nothing is written.
      S_FULL: begin
        if (rx_valid_i) err_d = 1'b1;
        if (!p_programm_i) state_d = S_RESTART;
      end

      S_RESTART: begin
        cpu_restart_o = 1'b1;
        state_d       = S_RUN;
      end

      default: state_d = S_RUN;
    endcase
  end

  assign err_o = err_q;

endmodule
